sequence_playback_ctrl: RTL and testbench

- Plays the stored memory sequence on the four LEDs for one round of the game.
- Fetches each sequence entry from the sequence RAM and lights the matching LED for ON_TICKS timer ticks, then blanks it for OFF_TICKS ticks.
- Schedules the shared tick timer: drives its enable, speed multiplier and clear, and picks a faster speed as the level rises.
- Sits between the game FSM (start/abort/done) and the timer plus sequence RAM.

---
 rtl/sequence_playback_ctrl.sv | 148 ++++++++++++++
 tb/tb_sequence_playback_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_playback_ctrl.sv
// Plays the stored sequence on four LEDs for one game round and schedules the shared tick timer.
// 3-cycle start-to-LED latency; abort returns to IDLE on the next cycle from any state.
module sequence_playback_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 1,
  parameter int CNT_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] level_i,
  input  logic              tick_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [1:0]        mem_data_i,
  output logic [3:0]        led_o,
  output logic              timer_en_o,
  output logic              timer_clr_o,
  output logic [1:0]        speed_mult_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'((OFF_TICKS > 0) ? OFF_TICKS - 1 : 0);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        led_q, led_d;
  logic [1:0]        speed_q, speed_d;
  logic              advance;

  // Any level bits above [3:0] push the value past 12, so compare on the full width.
  function automatic logic [1:0] speed_for(input logic [ADDR_W-1:0] lvl);
    logic [31:0] l;
    l = 32'(lvl);
    if (l >= 32'd12)     return 2'd0;
    else if (l >= 32'd8) return 2'd1;
    else if (l >= 32'd4) return 2'd2;
    else                 return 2'd3;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      speed_q <= 2'd3;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      speed_q <= speed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    speed_d = speed_q;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d   = level_i;
          speed_d = speed_for(level_i);
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        led_d   = 4'b0001 << mem_data_i;
        cnt_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (tick_i) begin
          if (cnt_q == ON_LAST) begin
            if (OFF_TICKS > 0) begin
              state_d = S_GAP;
              cnt_d   = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick_i) begin
          if (cnt_q == OFF_LAST) advance = 1'b1;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The last address ends the round rather than wrapping back to zero.
    if (advance) begin
      if (addr_q == len_q) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end

    if (abort_i) begin
      state_d = S_IDLE;
      addr_d  = '0;
      len_d   = '0;
      cnt_d   = '0;
      led_d   = '0;
    end
  end

  assign mem_addr_o   = addr_q;
  assign led_o        = (state_q == S_SHOW) ? led_q : 4'b0000;
  assign timer_en_o   = (state_q == S_SHOW) || (state_q == S_GAP);
  assign timer_clr_o  = (state_q == S_FETCH);
  assign speed_mult_o = speed_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_sequence_playback_ctrl.sv
// Bench for sequence_playback_ctrl: a default build and an OFF_TICKS=0 build share stimulus
// and are checked cycle by cycle against a step-level timeline model.
module tb_sequence_playback_ctrl;

  localparam int MAXC = 700;
  localparam int ON   = 3;

  logic       clk = 1'b0;
  logic       rst, start, abort, tick;
  logic [3:0] level;
  logic [1:0] mem_data0, mem_data1;
  logic [3:0] mem_addr0, mem_addr1, led0, led1;
  logic       en0, en1, clr0, clr1, busy0, busy1, done0, done1;
  logic [1:0] speed0, speed1;

  logic [1:0]  ram [16];
  bit          tick_arr [MAXC];
  logic [11:0] obs0 [MAXC];
  logic [11:0] obs1 [MAXC];
  logic [11:0] exp0 [MAXC];
  logic [11:0] exp1 [MAXC];
  logic [1:0]  spd0 [MAXC];
  logic [3:0]  last0, last1;
  int          checks, errors;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_data0 <= ram[mem_addr0];
    mem_data1 <= ram[mem_addr1];
  end

  sequence_playback_ctrl dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .level_i(level),
    .tick_i(tick), .mem_addr_o(mem_addr0), .mem_data_i(mem_data0), .led_o(led0),
    .timer_en_o(en0), .timer_clr_o(clr0), .speed_mult_o(speed0), .busy_o(busy0),
    .done_o(done0)
  );

  sequence_playback_ctrl #(.OFF_TICKS(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .level_i(level),
    .tick_i(tick), .mem_addr_o(mem_addr1), .mem_data_i(mem_data1), .led_o(led1),
    .timer_en_o(en1), .timer_clr_o(clr1), .speed_mult_o(speed1), .busy_o(busy1),
    .done_o(done1)
  );

  function automatic logic [3:0] onehot(input logic [1:0] b);
    logic [3:0] one;
    one = 4'b0001;
    return one << b;
  endfunction

  // Packed per-cycle observation: {busy, done, clr, en, led[3:0], addr[3:0]}
  function automatic logic [11:0] pk(input logic b, input logic d, input logic cl,
                                     input logic en, input logic [3:0] l, input logic [3:0] a);
    return {b, d, cl, en, l, a};
  endfunction

  task automatic gen_ticks(input int mode);
    for (int c = 0; c < MAXC; c++)
      tick_arr[c] = (mode == 0) ? ($urandom_range(0, 3) == 0) :
                    (mode == 1) ? ((c % 4) == 3) : 1'b1;
  endtask

  // Timeline model: start at cycle 0, then per step two fetch cycles, lit until ON ticks
  // have been seen, dark until `off` ticks have been seen; one done cycle ends the round.
  task automatic build_expect(input int len, input int off, input int abort_at,
                              input logic [3:0] init_addr, input int sel);
    logic [11:0] e [MAXC];
    int c, k;
    for (int i = 0; i < MAXC; i++) e[i] = pk(0, 0, 0, 0, 4'h0, init_addr);
    c = 1;
    for (int i = 0; i <= len; i++) begin
      if (c < MAXC)     e[c]     = pk(1, 0, 1, 0, 4'h0, 4'(i));
      if (c + 1 < MAXC) e[c + 1] = pk(1, 0, 0, 0, 4'h0, 4'(i));
      c += 2;
      k = 0;
      while (k < ON && c < MAXC) begin
        e[c] = pk(1, 0, 0, 1, onehot(ram[i]), 4'(i));
        if (tick_arr[c]) k++;
        c++;
      end
      k = 0;
      while (k < off && c < MAXC) begin
        e[c] = pk(1, 0, 0, 1, 4'h0, 4'(i));
        if (tick_arr[c]) k++;
        c++;
      end
    end
    if (c < MAXC) e[c] = pk(1, 1, 0, 0, 4'h0, 4'(len));
    c++;
    while (c < MAXC) begin
      e[c] = pk(0, 0, 0, 0, 4'h0, 4'(len));
      c++;
    end
    if (abort_at >= 0)
      for (int i = abort_at + 1; i < MAXC; i++) e[i] = pk(0, 0, 0, 0, 4'h0, 4'h0);
    for (int i = 0; i < MAXC; i++) begin
      if (sel == 0) exp0[i] = e[i];
      else          exp1[i] = e[i];
    end
  endtask

  // Drives one round (start at cycle 0, level scrambled afterwards) and records both DUTs.
  task automatic play(input int len, input int abort_at, input int extra_start);
    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == extra_start);
      abort = (c == abort_at);
      tick  = tick_arr[c];
      level = (c == 0) ? 4'(len) : 4'($urandom_range(0, 15));
      @(negedge clk);
      obs0[c] = pk(busy0, done0, clr0, en0, led0, mem_addr0);
      obs1[c] = pk(busy1, done1, clr1, en1, led1, mem_addr1);
      spd0[c] = speed0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    tick  = 1'b0;
    build_expect(len, 1, abort_at, last0, 0);
    build_expect(len, 0, abort_at, last1, 1);
    last0 = exp0[MAXC-1][3:0];
    last1 = exp1[MAXC-1][3:0];
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0; tick = 1'b0; level = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy0, led0, en0, done0, clr0, mem_addr0} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outs got b%0b led%b en%0b d%0b clr%0b a%0d exp all zero",
               busy0, led0, en0, done0, clr0, mem_addr0);
    end
    checks++;
    if (speed0 !== 2'd3 || speed1 !== 2'd3) begin
      errors++;
      $display("FAIL reset_speed got %0d/%0d exp 3", speed0, speed1);
    end
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle got busy %0b/%0b exp 0", busy0, busy1);
    end
    last0 = 4'h0;
    last1 = 4'h0;
  endtask

  task automatic test_single_step;
    int dcnt, dcyc;
    ram[0] = 2'd2;
    gen_ticks(1);
    play(0, -1, -1);
    dcnt = 0; dcyc = -1;
    for (int c = 0; c < MAXC; c++) begin
      checks++;
      if (obs0[c] !== exp0[c]) begin
        errors++;
        $display("FAIL single_trace0 cyc %0d got %h exp %h", c, obs0[c], exp0[c]);
      end
      checks++;
      if (obs1[c] !== exp1[c]) begin
        errors++;
        $display("FAIL single_trace1 cyc %0d got %h exp %h", c, obs1[c], exp1[c]);
      end
      if (obs0[c][10]) begin dcnt++; dcyc = c; end
    end
    checks++;
    if (dcnt != 1) begin
      errors++;
      $display("FAIL single_done_count got %0d exp 1", dcnt);
    end
    checks++;
    if (obs0[3][7:4] !== 4'b0100) begin
      errors++;
      $display("FAIL single_led_latency got %b exp 0100", obs0[3][7:4]);
    end
    checks++;
    if (dcyc < 0 || dcyc + 1 >= MAXC || obs0[dcyc + 1][11] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after_done got cyc %0d exp busy low after done", dcyc);
    end
  endtask

  task automatic test_multi_step;
    int clr_cnt, dcnt;
    ram[0] = 2'd1; ram[1] = 2'd3; ram[2] = 2'd0; ram[3] = 2'd2;
    gen_ticks(0);
    play(3, -1, -1);
    clr_cnt = 0; dcnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      checks++;
      if (obs0[c] !== exp0[c]) begin
        errors++;
        $display("FAIL multi_trace0 cyc %0d got %h exp %h", c, obs0[c], exp0[c]);
      end
      checks++;
      if (obs1[c] !== exp1[c]) begin
        errors++;
        $display("FAIL multi_trace1 cyc %0d got %h exp %h", c, obs1[c], exp1[c]);
      end
      if (obs0[c][9])  clr_cnt++;
      if (obs0[c][10]) dcnt++;
    end
    checks++;
    if (clr_cnt != 4 || dcnt != 1) begin
      errors++;
      $display("FAIL multi_counts got clr %0d done %0d exp clr 4 done 1", clr_cnt, dcnt);
    end
  endtask

  task automatic test_speed;
    int lv [4] = '{2, 5, 9, 15};
    int want;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) ram[i] = 2'($urandom_range(0, 3));
      gen_ticks(0);
      play(lv[t], -1, -1);
      want = 3 - (lv[t] / 4);
      checks++;
      if (spd0[1] !== 2'(want) || spd0[MAXC-1] !== 2'(want)) begin
        errors++;
        $display("FAIL speed_lv%0d got %0d/%0d exp %0d", lv[t], spd0[1], spd0[MAXC-1], want);
      end
      for (int c = 0; c < MAXC; c++) begin
        checks++;
        if (obs0[c] !== exp0[c]) begin
          errors++;
          $display("FAIL speed_trace0 lv %0d cyc %0d got %h exp %h", lv[t], c, obs0[c], exp0[c]);
        end
        checks++;
        if (obs1[c] !== exp1[c]) begin
          errors++;
          $display("FAIL speed_trace1 lv %0d cyc %0d got %h exp %h", lv[t], c, obs1[c], exp1[c]);
        end
      end
    end
  endtask

  task automatic test_abort;
    int a, dcnt;
    for (int i = 0; i < 16; i++) ram[i] = 2'($urandom_range(0, 3));
    gen_ticks(1);
    build_expect(5, 1, -1, last0, 0);
    a = -1;
    for (int c = 0; c < MAXC && a < 0; c++)
      if (exp0[c][7:4] != 4'h0 && exp0[c][3:0] == 4'd2) a = c + 1;
    if (a < 0) a = 40;
    tick_arr[a] = 1'b1;
    play(5, a, -1);
    dcnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      checks++;
      if (obs0[c] !== exp0[c]) begin
        errors++;
        $display("FAIL abort_trace0 cyc %0d got %h exp %h", c, obs0[c], exp0[c]);
      end
      checks++;
      if (obs1[c] !== exp1[c]) begin
        errors++;
        $display("FAIL abort_trace1 cyc %0d got %h exp %h", c, obs1[c], exp1[c]);
      end
      if (obs0[c][10]) dcnt++;
    end
    checks++;
    if (obs0[a + 1] !== 12'h000 || dcnt != 0) begin
      errors++;
      $display("FAIL abort_idle got %h done %0d exp 000 done 0", obs0[a + 1], dcnt);
    end
    checks++;
    if (spd0[MAXC-1] !== 2'd2) begin
      errors++;
      $display("FAIL abort_speed_hold got %0d exp 2", spd0[MAXC-1]);
    end
    gen_ticks(0);
    play(2, -1, -1);
    for (int c = 0; c < MAXC; c++) begin
      checks++;
      if (obs0[c] !== exp0[c]) begin
        errors++;
        $display("FAIL abort_replay0 cyc %0d got %h exp %h", c, obs0[c], exp0[c]);
      end
    end
  endtask

  task automatic test_ignored_inputs;
    for (int i = 0; i < 16; i++) ram[i] = 2'($urandom_range(0, 3));
    gen_ticks(2);
    play(5, -1, 9);
    for (int c = 0; c < MAXC; c++) begin
      checks++;
      if (obs0[c] !== exp0[c]) begin
        errors++;
        $display("FAIL ignored_trace0 cyc %0d got %h exp %h", c, obs0[c], exp0[c]);
      end
      checks++;
      if (obs1[c] !== exp1[c]) begin
        errors++;
        $display("FAIL ignored_trace1 cyc %0d got %h exp %h", c, obs1[c], exp1[c]);
      end
    end
  endtask

  task automatic test_no_gap;
    int gap_cyc;
    for (int i = 0; i < 16; i++) ram[i] = 2'($urandom_range(0, 3));
    gen_ticks(0);
    play(7, -1, -1);
    gap_cyc = 0;
    for (int c = 0; c < MAXC; c++) begin
      checks++;
      if (obs1[c] !== exp1[c]) begin
        errors++;
        $display("FAIL nogap_trace1 cyc %0d got %h exp %h", c, obs1[c], exp1[c]);
      end
      if (obs1[c][8] && obs1[c][7:4] == 4'h0) gap_cyc++;
    end
    checks++;
    if (gap_cyc != 0) begin
      errors++;
      $display("FAIL nogap_dark_enabled got %0d exp 0", gap_cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) ram[i] = 2'd0;
    test_reset;
    test_single_step;
    test_multi_step;
    test_speed;
    test_abort;
    test_ignored_inputs;
    test_no_gap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
